switch_debouncer: RTL and testbench

- Input-conditioning stage between the board slide switches/buttons and the LED controller, 7-segment and clock-divider logic.
- Synchronises each raw switch bit to clk and debounces it against a shared, internally generated tick.
- Outputs a clean level per bit, plus one-clk rise/fall pulses.
- Also exports the tick as a clock-enable so downstream display scanning runs on clk instead of a derived clock.

---
 rtl/switch_debouncer_pkg.sv | 26 ++
 rtl/switch_debouncer_checker.sv | 30 +++
 rtl/switch_debouncer_debounce_cell.sv | 83 ++++++++
 rtl/switch_debouncer.sv | 103 ++++++++++
 tb/tb_switch_debouncer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared board constants and helpers for the switch input-conditioning stage.
package switch_debouncer_pkg;

   localparam int BOARD_CLK_HZ          = 100_000_000;
   localparam int DEBOUNCE_TICK_HZ      = 1000;
   localparam int DEBOUNCE_STABLE_TICKS = 20;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_kind_e;

   // Ceiling log2, floored at 1 so a counter is never zero bits wide.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/switch_debouncer_checker.sv
// Structural properties of the debouncer outputs, checked in simulation.
module switch_debouncer_checker #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   input logic [WIDTH-1:0] sw_level,
   input logic [WIDTH-1:0] sw_rise,
   input logic [WIDTH-1:0] sw_fall,
   input logic             any_change,
   input logic             tick
);

   a_rise_fall_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      (sw_rise & sw_fall) == {WIDTH{1'b0}});

   a_any_change_is_or : assert property (@(posedge clk) disable iff (!rst_n)
      any_change == (|(sw_rise | sw_fall)));

   // A pulse always coincides with the first cycle of the new level.
   a_rise_matches_level : assert property (@(posedge clk) disable iff (!rst_n)
      (sw_rise & ~sw_level) == {WIDTH{1'b0}});

   a_fall_matches_level : assert property (@(posedge clk) disable iff (!rst_n)
      (sw_fall & sw_level) == {WIDTH{1'b0}});

   a_tick_single_cycle : assert property (@(posedge clk) disable iff (!rst_n)
      tick |=> !tick);

endmodule

// File: rtl/switch_debouncer_debounce_cell.sv
// One switch bit: two-flop synchroniser, tick-qualified stability counter,
// debounced level and one-clk rise/fall pulses.
module switch_debouncer_debounce_cell
   import switch_debouncer_pkg::*;
#(
   parameter int   STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   input  logic tick,
   output logic sw_level,
   output logic sw_rise,
   output logic sw_fall,
   output logic accept
);

   localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

   logic             meta_r;
   logic             sync_r;
   logic             level_r;
   logic [CNT_W-1:0] cnt_r;
   logic             rise_r;
   logic             fall_r;

   logic [CNT_W-1:0] cnt_nxt_s;
   logic             level_nxt_s;
   edge_kind_e       edge_s;

   // Two-stage synchroniser for the asynchronous switch input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= sw_raw;
         sync_r <= meta_r;
      end
   end

   // Qualification: a mismatch must survive STABLE_TICKS ticks; any match restarts it.
   always_comb begin
      cnt_nxt_s   = '0;
      level_nxt_s = level_r;
      edge_s      = EDGE_NONE;
      if (sync_r == level_r) begin
         cnt_nxt_s = '0;
      end else if (!tick) begin
         cnt_nxt_s = cnt_r;
      end else if (cnt_r < LAST_CNT) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s   = '0;
         level_nxt_s = sync_r;
         edge_s      = sync_r ? EDGE_RISE : EDGE_FALL;
      end
   end

   // Counter, level and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         level_r <= RESET_VAL;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         level_r <= level_nxt_s;
         rise_r  <= (edge_s == EDGE_RISE);
         fall_r  <= (edge_s == EDGE_FALL);
      end
   end

   // accept is the unregistered decision so the top can align any_change with the pulses.
   assign accept   = (edge_s != EDGE_NONE);
   assign sw_level = level_r;
   assign sw_rise  = rise_r;
   assign sw_fall  = fall_r;

endmodule

// File: rtl/switch_debouncer.sv
// Switch input conditioning: shared tick prescaler, per-bit debounce cells and
// a combined change strobe; tick doubles as a clock-enable for downstream logic.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter int               CLK_HZ       = BOARD_CLK_HZ,
   parameter int               TICK_HZ      = DEBOUNCE_TICK_HZ,
   parameter int               STABLE_TICKS = DEBOUNCE_STABLE_TICKS,
   parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_level,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             any_change,
   output logic             tick
);

   localparam int               PERIOD   = CLK_HZ / TICK_HZ;
   localparam int               PRE_W    = clog2(PERIOD);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);

   if (PERIOD < 32'sd2) begin : g_bad_period
      $error("switch_debouncer: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (STABLE_TICKS < 32'sd1) begin : g_bad_stable
      $error("switch_debouncer: STABLE_TICKS must be at least 1");
   end
   if (WIDTH < 32'sd1) begin : g_bad_width
      $error("switch_debouncer: WIDTH must be at least 1");
   end

   logic [PRE_W-1:0] pre_cnt_r;
   logic [PRE_W-1:0] pre_cnt_nxt_s;
   logic             tick_r;
   logic             any_change_r;
   logic [WIDTH-1:0] accept_s;

   // Prescaler wraps at PERIOD-1.
   always_comb begin
      pre_cnt_nxt_s = '0;
      if (pre_cnt_r == PRE_LAST) begin
         pre_cnt_nxt_s = '0;
      end else begin
         pre_cnt_nxt_s = pre_cnt_r + PRE_W'(1);
      end
   end

   // Tick is registered off the terminal count, so the first one lands PERIOD clocks after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_r <= '0;
         tick_r    <= 1'b0;
      end else begin
         pre_cnt_r <= pre_cnt_nxt_s;
         tick_r    <= (pre_cnt_r == PRE_LAST);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      switch_debouncer_debounce_cell #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_VAL    (RESET_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_raw   (sw_raw[i]),
         .tick     (tick_r),
         .sw_level (sw_level[i]),
         .sw_rise  (sw_rise[i]),
         .sw_fall  (sw_fall[i]),
         .accept   (accept_s[i])
      );
   end

   // Change strobe registered from the same decisions that set the pulse flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_change_r <= 1'b0;
      end else begin
         any_change_r <= |accept_s;
      end
   end

   assign tick       = tick_r;
   assign any_change = any_change_r;

   switch_debouncer_checker #(
      .WIDTH (WIDTH)
   ) u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_level   (sw_level),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .any_change (any_change),
      .tick       (tick)
   );

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with P=10 clk, STABLE_TICKS=4, WIDTH=8.
module tb_switch_debouncer;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] sw_raw = 8'h00;
   logic [7:0] sw_level;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;
   logic       any_change;
   logic       tick;

   switch_debouncer #(
      .WIDTH        (8),
      .CLK_HZ       (1000),
      .TICK_HZ      (100),
      .STABLE_TICKS (4),
      .RESET_VAL    (8'h00)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw),
      .sw_level   (sw_level),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .any_change (any_change),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] level;
      int         lo;
      int         hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total  = 0;
   int   bad    = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Acceptance must fall 33..42 clk after the input edge driven at cycle c.
   task automatic push_exp(input logic [7:0] rise, input logic [7:0] fall,
                           input logic [7:0] level, input int lo, input int hi);
      exp_t e;
      e.rise  = rise;
      e.fall  = fall;
      e.level = level;
      e.lo    = lo;
      e.hi    = hi;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (15) @(negedge clk);
   endtask

   // Every pulse cycle must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mon_en && (((sw_rise | sw_fall) != 8'h00) || any_change)) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_pulse", {15'd0, any_change, sw_rise, sw_fall}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("rise", 32'(sw_rise), 32'(mon_e.rise));
            check_val("fall", 32'(sw_fall), 32'(mon_e.fall));
            check_val("level", 32'(sw_level), 32'(mon_e.level));
            check_val("any_change", 32'(any_change), 32'd1);
            check_val("latency", (cyc >= mon_e.lo && cyc <= mon_e.hi) ? 32'(mon_e.lo) : 32'(cyc),
                      32'(mon_e.lo));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      int c;

      repeat (3) @(negedge clk);
      check_val("rst_level", 32'(sw_level), 32'h0);
      check_val("rst_pulses", {15'd0, any_change, sw_rise, sw_fall}, 32'd0);
      check_val("rst_tick", 32'(tick), 32'd0);
      rst_n  = 1'b1;
      r      = cyc;
      mon_en = 1'b1;

      // Idle after reset: tick every 10 clk, level stays at reset value.
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         check_val("tick", 32'(tick), 32'(((cyc - r) % 10) == 0));
         if ((k % 25) == 0) check_val("idle_level", 32'(sw_level), 32'h0);
      end

      // Clean press on bit 0.
      @(negedge clk);
      sw_raw[0] = 1'b1;
      c = cyc;
      push_exp(8'h01, 8'h00, 8'h01, c + 33, c + 42);
      drain(60);

      // Bounce on bit 3 every 7 clk, never stable long enough.
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if ((k % 7) == 0) sw_raw[3] = ~sw_raw[3];
      end
      sw_raw[3] = 1'b0;
      repeat (60) @(negedge clk);
      check_val("bounce_level", 32'(sw_level), 32'h01);

      // Short high on bit 5, a 3-clk dropout, then stable high.
      @(negedge clk);
      sw_raw[5] = 1'b1;
      repeat (25) @(negedge clk);
      sw_raw[5] = 1'b0;
      repeat (3) @(negedge clk);
      sw_raw[5] = 1'b1;
      c = cyc;
      push_exp(8'h20, 8'h00, 8'h21, c + 33, c + 42);
      drain(60);

      // All bits high, then simultaneous release of the upper nibble.
      @(negedge clk);
      sw_raw = 8'hFF;
      c = cyc;
      push_exp(8'hDE, 8'h00, 8'hFF, c + 33, c + 42);
      drain(60);
      @(negedge clk);
      sw_raw = 8'h0F;
      c = cyc;
      push_exp(8'h00, 8'hF0, 8'h0F, c + 33, c + 42);
      drain(60);
      @(negedge clk);
      sw_raw = 8'h00;
      c = cyc;
      push_exp(8'h00, 8'h0F, 8'h00, c + 33, c + 42);
      drain(60);

      // Reset part-way through qualifying bit 1.
      @(negedge clk);
      sw_raw[1] = 1'b1;
      repeat (25) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_val("midrst_level", 32'(sw_level), 32'h0);
      end
      rst_n = 1'b1;
      r = cyc;
      push_exp(8'h02, 8'h00, 8'h02, r + 32, r + 42);
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         check_val("postrst_level", 32'(sw_level), 32'h0);
      end
      drain(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
